// File: rtl/serial_deserializer_if.sv
// ---------------------------------------------------------------------------
// serial_deserializer_if
//  Bundles the serial input stream and the parallel word output of the
//  serial_deserializer. clk and reset stay outside the bundle as plain ports.
//
//  Signals
//   En          bit-valid enable (driver -> deserializer)
//   D           serial data bit (driver -> deserializer)
//   clear       synchronous abort of a partial word (driver -> deserializer)
//   data_out    last completed word (deserializer -> consumer)
//   word_valid  one-cycle strobe when data_out is updated
//   busy        a word is partially assembled
//   bit_count   data bits captured in the current word
//   parity_err  one-cycle strobe with word_valid on bad parity
//
//  Modports
//   master  drives En/D/clear, observes the word outputs
//   slave   the deserializer itself
// ---------------------------------------------------------------------------
interface serial_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) ();

  logic             En;
  logic             D;
  logic             clear;
  logic [WIDTH-1:0] data_out;
  logic             word_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_count;
  logic             parity_err;

  modport master (
    output En,
    output D,
    output clear,
    input  data_out,
    input  word_valid,
    input  busy,
    input  bit_count,
    input  parity_err
  );

  modport slave (
    input  En,
    input  D,
    input  clear,
    output data_out,
    output word_valid,
    output busy,
    output bit_count,
    output parity_err
  );

endinterface

// File: rtl/serial_deserializer.sv
// ---------------------------------------------------------------------------
// serial_deserializer
//  Assembles WIDTH-bit words, MSB first, from the registered serial stream
//  (D qualified by En). Each completed word is presented on data_out together
//  with a one-cycle word_valid strobe; data_out then holds until the next
//  completion. Back-to-back words are supported: a bit arriving in the DONE
//  cycle becomes the first bit of the next word.
//
//  Optional feature: define DESER_PARITY_EN to expect one extra serial bit
//  after every word. Even parity over the WIDTH data bits plus the parity bit
//  is required; a mismatch raises parity_err alongside word_valid (the word is
//  still delivered). With the macro undefined there is no PARITY state and
//  parity_err is tied low.
//
//  Ports
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    serial_deserializer_if.slave (En, D, clear in; data_out,
//          word_valid, busy, bit_count, parity_err out)
//
//  States
//   IDLE   | no word in progress, waiting for the first bit
//   SHIFT  | collecting data bits, bit_count holds bits captured so far
//   PARITY | all data bits in, waiting for the parity bit (macro only)
//   DONE   | word_valid cycle; data_out carries the new word
// ---------------------------------------------------------------------------
module serial_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  serial_deserializer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef DESER_PARITY_EN
    PARITY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_out_q;
  logic             word_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] bit_count_q;
  logic             parity_err_q;

  // First captured bit ends up in the MSB after WIDTH shifts.
  assign shifted = {shift_reg[WIDTH-2:0], bus.D};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      data_out_q   <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      bit_count_q  <= '0;
      parity_err_q <= 1'b0;
    end else begin
      // Strobes are high only in the DONE cycle; every entry into DONE
      // re-asserts them explicitly below.
      word_valid_q <= 1'b0;
      parity_err_q <= 1'b0;

      if (bus.clear) begin
        // Abort wins over En everywhere; the last completed word is kept.
        state       <= IDLE;
        shift_reg   <= '0;
        bit_count_q <= '0;
        busy_q      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.En) begin
              shift_reg   <= shifted;
              bit_count_q <= CNT_W'(1);
              busy_q      <= 1'b1;
              state       <= SHIFT;
            end
          end

          SHIFT: begin
            if (bus.En) begin
              shift_reg <= shifted;
              if (bit_count_q == LAST_BIT) begin
                bit_count_q <= '0;
`ifdef DESER_PARITY_EN
                state       <= PARITY;
`else
                data_out_q   <= shifted;
                word_valid_q <= 1'b1;
                busy_q       <= 1'b0;
                state        <= DONE;
`endif
              end else begin
                bit_count_q <= bit_count_q + CNT_W'(1);
              end
            end
          end

`ifdef DESER_PARITY_EN
          PARITY: begin
            if (bus.En) begin
              // Even parity: data bits plus parity bit must XOR to zero.
              data_out_q   <= shift_reg;
              parity_err_q <= ^{shift_reg, bus.D};
              word_valid_q <= 1'b1;
              busy_q       <= 1'b0;
              state        <= DONE;
            end
          end
`endif

          DONE: begin
            if (bus.En) begin
              // Next word starts immediately so no bit is lost.
              shift_reg   <= shifted;
              bit_count_q <= CNT_W'(1);
              busy_q      <= 1'b1;
              state       <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end

          default: begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_count_q <= '0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef DESER_PARITY_EN
  // Without the parity stage the word is taken from the shift path, so the
  // register MSB is never read back.
  logic unused_shift_msb;
  assign unused_shift_msb = shift_reg[WIDTH-1];
`endif

  assign bus.data_out   = data_out_q;
  assign bus.word_valid = word_valid_q;
  assign bus.busy       = busy_q;
  assign bus.bit_count  = bit_count_q;
`ifdef DESER_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
  logic unused_parity_err;
  assign unused_parity_err = parity_err_q;
`endif

endmodule
